// File: rtl/systolic_feeder.sv
// systolic_feeder: holds two 3x3 operand matrices loaded element by element and,
// on start, streams them as skewed columns (A) and rows (B) into a downstream
// systolic array. The stream is followed by a run of zero-drive flush cycles.
// Optional feature macro: FEEDER_LOADCHK_EN (start only accepted once every
// element of both matrices has been written since the last done or reset).
module systolic_feeder #(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned GRID_SIZE    = 3,
    parameter int unsigned FLUSH_CYCLES = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic                 ld_mat,
    input  logic [3:0]           ld_idx,
    input  logic [DATA_SIZE-1:0] ld_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [DATA_SIZE-1:0] a1,
    output logic [DATA_SIZE-1:0] a2,
    output logic [DATA_SIZE-1:0] a3,
    output logic [DATA_SIZE-1:0] b1,
    output logic [DATA_SIZE-1:0] b2,
    output logic [DATA_SIZE-1:0] b3
);

    localparam int unsigned N          = GRID_SIZE;
    localparam int unsigned NUM_ELEM   = N * N;
    localparam int unsigned STREAM_LEN = 2 * N - 1;
    localparam int unsigned T_W        = $clog2(STREAM_LEN);
    localparam int unsigned F_W        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t               r_state;
    logic [T_W-1:0]       r_t;
    logic [F_W-1:0]       r_fcnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ld_ready;

    logic [DATA_SIZE-1:0] r_mat_a [NUM_ELEM];
    logic [DATA_SIZE-1:0] r_mat_b [NUM_ELEM];

    logic [DATA_SIZE-1:0] w_a [N];
    logic [DATA_SIZE-1:0] w_b [N];
    logic [DATA_SIZE-1:0] r_a1, r_a2, r_a3, r_b1, r_b2, r_b3;

    logic w_wr;
    logic w_stream_last;
    logic w_flush_last;
    logic w_start_ok;

    // Writes are taken only in IDLE; out-of-range indices are accepted but dropped
    assign w_wr          = ld_valid && (r_state == ST_IDLE) && (ld_idx < 4'(NUM_ELEM));
    assign w_stream_last = (r_state == ST_STREAM) && (r_t == T_W'(STREAM_LEN - 1));
    assign w_flush_last  = (r_state == ST_FLUSH) && (r_fcnt == F_W'(FLUSH_CYCLES - 1));

`ifdef FEEDER_LOADCHK_EN
    logic                r_err;
    logic [NUM_ELEM-1:0] r_mask_a;
    logic [NUM_ELEM-1:0] r_mask_b;
    logic [NUM_ELEM-1:0] w_set;
    logic [NUM_ELEM-1:0] w_mask_a_nxt;
    logic [NUM_ELEM-1:0] w_mask_b_nxt;

    // A write landing in the start cycle counts toward completeness
    assign w_set        = w_wr ? (NUM_ELEM'(1) << ld_idx) : {NUM_ELEM{1'b0}};
    assign w_mask_a_nxt = r_mask_a | (ld_mat ? {NUM_ELEM{1'b0}} : w_set);
    assign w_mask_b_nxt = r_mask_b | (ld_mat ? w_set : {NUM_ELEM{1'b0}});
    assign w_start_ok   = (&w_mask_a_nxt) && (&w_mask_b_nxt);
    assign err          = r_err;

    // Written-element masks, cleared at the end of every run
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask_a <= '0;
            r_mask_b <= '0;
        end else if (w_flush_last) begin
            r_mask_a <= '0;
            r_mask_b <= '0;
        end else begin
            r_mask_a <= w_mask_a_nxt;
            r_mask_b <= w_mask_b_nxt;
        end
    end
`else
    assign w_start_ok = 1'b1;
    assign err        = 1'b0;
`endif

    // Operand storage; untouched by runs so a second start replays the same data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_ELEM); i++) begin
                r_mat_a[i] <= '0;
                r_mat_b[i] <= '0;
            end
        end else if (w_wr) begin
            if (ld_mat) begin
                r_mat_b[ld_idx] <= ld_data;
            end else begin
                r_mat_a[ld_idx] <= ld_data;
            end
        end
    end

    // Run sequencer: IDLE -> STREAM (2N-1 cycles) -> FLUSH (FLUSH_CYCLES) -> IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_t        <= '0;
            r_fcnt     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ld_ready <= 1'b1;
`ifdef FEEDER_LOADCHK_EN
            r_err      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef FEEDER_LOADCHK_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (start && w_start_ok) begin
                        r_state    <= ST_STREAM;
                        r_t        <= '0;
                        r_busy     <= 1'b1;
                        r_ld_ready <= 1'b0;
                    end
`ifdef FEEDER_LOADCHK_EN
                    if (start && !w_start_ok) begin
                        r_err <= 1'b1;
                    end
`endif
                end
                ST_STREAM: begin
                    if (w_stream_last) begin
                        r_state <= ST_FLUSH;
                        r_fcnt  <= '0;
                        if (FLUSH_CYCLES == 1) begin
                            r_done <= 1'b1;
                        end
                    end else begin
                        r_t <= r_t + T_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (w_flush_last) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_ld_ready <= 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt + F_W'(1);
                        if (r_fcnt == F_W'(FLUSH_CYCLES - 2)) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_ld_ready <= 1'b1;
                end
            endcase
        end
    end

    // Skew selection: column j of A and row j of B are delayed by j stream steps
    always_comb begin
        for (int j = 0; j < int'(N); j++) begin
            w_a[j] = '0;
            w_b[j] = '0;
        end
        if (r_state == ST_STREAM) begin
            for (int j = 0; j < int'(N); j++) begin
                if ((int'(r_t) >= j) && ((int'(r_t) - j) <= int'(N) - 1)) begin
                    w_a[j] = r_mat_a[4'((int'(r_t) - j) * int'(N) + j)];
                    w_b[j] = r_mat_b[4'(j * int'(N) + (int'(r_t) - j))];
                end
            end
        end
    end

    // Registered feed outputs, zero outside STREAM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a1 <= '0;
            r_a2 <= '0;
            r_a3 <= '0;
            r_b1 <= '0;
            r_b2 <= '0;
            r_b3 <= '0;
        end else begin
            r_a1 <= w_a[0];
            r_a2 <= w_a[1];
            r_a3 <= w_a[2];
            r_b1 <= w_b[0];
            r_b2 <= w_b[1];
            r_b3 <= w_b[2];
        end
    end

    assign ld_ready = r_ld_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign a1       = r_a1;
    assign a2       = r_a2;
    assign a3       = r_a3;
    assign b1       = r_b1;
    assign b2       = r_b2;
    assign b3       = r_b3;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a cycle table for the 1..9 / identity run, directed
// corner sequences, and random matrices checked against a skew model.
module tb_systolic_feeder;

    logic       clk;
    logic       reset;
    logic       ld_valid;
    logic       ld_ready;
    logic       ld_mat;
    logic [3:0] ld_idx;
    logic [7:0] ld_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] a1, a2, a3, b1, b2, b3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ma [9];
    logic [7:0] mb [9];
    int         perm [18];

    typedef struct {
        logic        start;
        logic [23:0] a;
        logic [23:0] b;
        logic        busy;
        logic        done;
        logic        rdy;
    } vec_t;

    vec_t tbl [14];

    systolic_feeder #(
        .DATA_SIZE   (8),
        .GRID_SIZE   (3),
        .FLUSH_CYCLES(7)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_mat  (ld_mat),
        .ld_idx  (ld_idx),
        .ld_data (ld_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .a1      (a1),
        .a2      (a2),
        .a3      (a3),
        .b1      (b1),
        .b2      (b2),
        .b3      (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic [23:0] a, input logic [23:0] b,
                                input logic bz, input logic dn, input logic rd);
        vec_t v;
        v.start = s; v.a = a; v.b = b; v.busy = bz; v.done = dn; v.rdy = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called and returns just after a falling edge
    task automatic load(input logic m, input int idx, input logic [7:0] d);
        ld_valid = 1'b1;
        ld_mat   = m;
        ld_idx   = 4'(idx);
        ld_data  = d;
        @(negedge clk);
        ld_valid = 1'b0;
        if (idx < 9) begin
            if (m) mb[idx] = d;
            else   ma[idx] = d;
        end
    endtask

    task automatic load_ident();
        for (int i = 0; i < 9; i++) begin
            load(1'b0, i, 8'(i + 1));
            load(1'b1, i, (i % 4 == 0) ? 8'd1 : 8'd0);
        end
    endtask

    task automatic reload_if_checked();
`ifdef FEEDER_LOADCHK_EN
        load_ident();
`endif
    endtask

    task automatic run_table(input string tag, input bit restart, input bit hold_ld);
        for (int r = 0; r < 14; r++) begin
            chk({tag, "_a"},    {8'h0, a1, a2, a3}, {8'h0, tbl[r].a});
            chk({tag, "_b"},    {8'h0, b1, b2, b3}, {8'h0, tbl[r].b});
            chk({tag, "_busy"}, 32'(busy),     32'(tbl[r].busy));
            chk({tag, "_done"}, 32'(done),     32'(tbl[r].done));
            chk({tag, "_rdy"},  32'(ld_ready), 32'(tbl[r].rdy));
            chk({tag, "_err"},  32'(err),      32'd0);
            start    = tbl[r].start | (restart && r == 3);
            ld_valid = hold_ld && (r >= 1) && (r <= 12);
            ld_mat   = 1'(r & 1);
            ld_idx   = 4'(r % 9);
            ld_data  = 8'hEE;
            @(negedge clk);
        end
        start    = 1'b0;
        ld_valid = 1'b0;
    endtask

    // Reference: element A[r][j] enters column j at stream step r+j; B[i][c] enters row i at step i+c
    task automatic run_model(input string tag, input bit sc_wr, input logic sc_mat,
                             input logic [3:0] sc_idx, input logic [7:0] sc_data);
        logic [23:0] ea [14];
        logic [23:0] eb [14];
        bit          eb_busy;
        if (sc_wr && sc_idx < 9) begin
            if (sc_mat) mb[sc_idx] = sc_data;
            else        ma[sc_idx] = sc_data;
        end
        for (int r = 0; r < 14; r++) begin
            ea[r] = '0;
            eb[r] = '0;
        end
        for (int j = 0; j < 3; j++) begin
            for (int r = 0; r < 3; r++) begin
                ea[r + j + 2][23 - 8 * j -: 8] = ma[r * 3 + j];
                eb[r + j + 2][23 - 8 * j -: 8] = mb[j * 3 + r];
            end
        end
        for (int r = 0; r < 14; r++) begin
            eb_busy = (r >= 1) && (r <= 12);
            chk({tag, "_a"},    {8'h0, a1, a2, a3}, {8'h0, ea[r]});
            chk({tag, "_b"},    {8'h0, b1, b2, b3}, {8'h0, eb[r]});
            chk({tag, "_busy"}, 32'(busy),     32'(eb_busy));
            chk({tag, "_done"}, 32'(done),     32'(r == 12));
            chk({tag, "_rdy"},  32'(ld_ready), 32'(!eb_busy));
            start    = (r == 0);
            ld_valid = sc_wr && (r == 0);
            ld_mat   = sc_mat;
            ld_idx   = sc_idx;
            ld_data  = sc_data;
            @(negedge clk);
        end
        start    = 1'b0;
        ld_valid = 1'b0;
    endtask

    initial begin
        int dn_cnt;
        int bz_cnt;
        int tmp;
        int k;

        tbl[0]  = mk(1'b1, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1);
        tbl[1]  = mk(1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 24'h010000, 24'h010000, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 24'h040200, 24'h000000, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 24'h070503, 24'h000100, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 24'h000806, 24'h000000, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 24'h000009, 24'h000001, 1'b1, 1'b0, 1'b0);
        for (int r = 7; r < 12; r++) tbl[r] = mk(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 24'h000000, 24'h000000, 1'b1, 1'b1, 1'b0);
        tbl[13] = mk(1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 9; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        reset    = 1'b0;
        ld_valid = 1'b0;
        ld_mat   = 1'b0;
        ld_idx   = '0;
        ld_data  = '0;
        start    = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_a",    {8'h0, a1, a2, a3}, 32'h0);
        chk("rst_b",    {8'h0, b1, b2, b3}, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 32'(ld_ready), 32'd1);

        load_ident();
        run_table("basic", 1'b0, 1'b0);
        reload_if_checked();
        run_table("restart", 1'b1, 1'b0);
        reload_if_checked();
        run_table("ld_busy", 1'b0, 1'b1);
        reload_if_checked();
        run_table("replay", 1'b0, 1'b0);
        reload_if_checked();
        load(1'b0, 12, 8'hFF);
        load(1'b1, 12, 8'hFF);
        run_table("idx12", 1'b0, 1'b0);

        reload_if_checked();
        run_model("same_cycle_wr", 1'b1, 1'b0, 4'd4, 8'h5A);

        // Reset in the middle of a run
        load_ident();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrun_a", {8'h0, a1, a2, a3}, 32'h040200);
        reset = 1'b0;
        #1;
        chk("abort_a",    {8'h0, a1, a2, a3}, 32'h0);
        chk("abort_b",    {8'h0, b1, b2, b3}, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        dn_cnt = 0;
        bz_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) dn_cnt++;
            if (busy) bz_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(dn_cnt), 32'd0);
        chk("abort_idle",    32'(bz_cnt), 32'd0);
`ifndef FEEDER_LOADCHK_EN
        run_model("zero_store", 1'b0, 1'b0, 4'd0, 8'd0);
`endif
        load_ident();
        run_table("after_rst", 1'b0, 1'b0);

`ifdef FEEDER_LOADCHK_EN
        // 17 of 18 elements written: start must be refused
        for (int i = 0; i < 9; i++) load(1'b0, i, 8'(8'h20 + i));
        for (int i = 0; i < 8; i++) load(1'b1, i, 8'(8'h40 + i));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("partial_err",  32'(err),  32'd1);
        chk("partial_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("partial_err_pulse", 32'(err),  32'd0);
        chk("partial_idle",      32'(busy), 32'd0);
        load(1'b1, 8, 8'h48);
        run_model("full_load", 1'b0, 1'b0, 4'd0, 8'd0);
`endif

        // Random matrices loaded in random order, with stray extra writes
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 18; i++) perm[i] = i;
            for (int i = 17; i > 0; i--) begin
                k       = int'($urandom_range(32'(i), 0));
                tmp     = perm[i];
                perm[i] = perm[k];
                perm[k] = tmp;
            end
            for (int i = 0; i < 18; i++) load(perm[i] >= 9, perm[i] % 9, 8'($urandom));
            tmp = int'($urandom_range(3, 0));
            for (int i = 0; i < tmp; i++) load(1'($urandom), int'($urandom_range(15, 0)), 8'($urandom));
            run_model("rand", 1'($urandom), 1'($urandom), 4'($urandom_range(11, 0)), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter DATA_SIZE, default 8, element width in bits.
REQ-002 Parameter GRID_SIZE, default 3, array dimension N; only 3 is supported.
REQ-003 Parameter FLUSH_CYCLES, default 7, number of zero-drive cycles after streaming.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ld_valid  input  1  load element request.
REQ-007 ld_ready  output  1  element accepted when ld_valid && ld_ready.
REQ-008 ld_mat  input  1  target matrix: 0=A, 1=B.
REQ-009 ld_idx  input  4  row-major index 0..8 (row = idx/3, col = idx%3).
REQ-010 ld_data  input  DATA_SIZE  element value.
REQ-011 start  input  1  single-cycle pulse that begins a run.
REQ-012 busy  output  1  high during STREAM and FLUSH.
REQ-013 done  output  1  one-cycle pulse on the last FLUSH cycle.
REQ-014 err  output  1  one-cycle pulse when start is rejected (REQ-033).
REQ-015 a1, a2, a3  output  DATA_SIZE each  skewed A columns feeding the downstream array.
REQ-016 b1, b2, b3  output  DATA_SIZE each  skewed B rows feeding the downstream array.

Function
REQ-017 States: IDLE, STREAM, FLUSH; there is no separate load state.
REQ-018 ld_ready is high only in IDLE.
REQ-019 An accepted element is written to A[idx] or B[idx] on the same clock edge.
REQ-020 A write with ld_idx > 8 is accepted and discarded.
REQ-021 Writes to the same index overwrite; the last write wins.
REQ-022 IDLE->STREAM on start; the stream counter t clears to 0.
REQ-023 STREAM lasts 2N-1 = 5 cycles (t = 0..4); STREAM->FLUSH after t = 4.
REQ-024 FLUSH lasts FLUSH_CYCLES cycles; FLUSH->IDLE after the last one, with done high during that last cycle.
REQ-025 In STREAM, a_j = A[t-(j-1)][j-1] when 0 <= t-(j-1) <= 2, else 0, for j = 1..3.
REQ-026 In STREAM, b_i = B[i-1][t-(i-1)] when 0 <= t-(i-1) <= 2, else 0, for i = 1..3.
REQ-027 All a/b outputs are registered: values for stream cycle t appear the cycle after that state/t is registered, and are held as 0 in IDLE and FLUSH.
REQ-028 start while busy is ignored, with no err pulse.
REQ-029 start and ld_valid in the same IDLE cycle: the write is accepted and the run starts, using the updated value.
REQ-030 Matrix storage is not modified by a run; a second start replays the same matrices.
REQ-031 No arithmetic is performed; values pass unmodified and unsigned.

Reset
REQ-032 When reset is asserted (low, async): state = IDLE, t = 0, all a/b outputs = 0, busy = 0, done = 0, err = 0, ld_ready = 1 after release, and A/B storage = 0. Reset asserted mid-run aborts the run with no done pulse.

Configuration
REQ-033 Macro FEEDER_LOADCHK_EN, when defined: two 9-bit written-masks track writes to A and B since the last done or reset. start is accepted only if both masks are all ones; otherwise it stays in IDLE and pulses err for one cycle. Masks clear on done.
REQ-034 When FEEDER_LOADCHK_EN is undefined: start is always accepted in IDLE, err is tied to 0, and no mask logic exists.

Verification
REQ-035 Load A = 1..9 and B = identity, then start: a1 over t = 0..4 reads 1,4,7,0,0; a3 reads 0,0,3,6,9; b2 reads 0,0,1,0,0; busy is high for 12 cycles; done pulses once.
REQ-036 start pulsed again during STREAM: no restart, and done occurs exactly 12 cycles after the first start.
REQ-037 ld_valid held during busy: ld_ready = 0 and storage unchanged; second run outputs identical to the first.
REQ-038 reset dropped at t = 2: all outputs 0 immediately, state IDLE, no done; a new start after reloading streams correctly.
REQ-039 With FEEDER_LOADCHK_EN defined, only 17 elements loaded then start: err = 1 for one cycle, busy stays 0; load the 18th element then start: run proceeds normally.
REQ-040 ld_idx = 12 with data 0xFF: no storage change, and all outputs match REQ-035.
